// File: rtl/fir_pkg.sv
// Shared types and constants for the symmetric-FIR tap sequencer.
// SYM_FIR_ODD_TAPS_EN selects odd-length support (centre tap has no mirror).
package fir_pkg;

    localparam int DATA_W = 24;
    localparam int COEF_W = 18;
    localparam int PROD_W = DATA_W + 1 + COEF_W;

    typedef enum logic {IDLE, RUN} seq_state_e;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    // Number of (a, c) pairs emitted per sample, which is also the coefficient bank depth.
    function automatic int fir_num_pairs(input int n);
`ifdef SYM_FIR_ODD_TAPS_EN
        return (n + 1) / 2;
`else
        return n / 2;
`endif
    endfunction

    function automatic int fir_addr_w(input int n);
        return (fir_num_pairs(n) > 1) ? $clog2(fir_num_pairs(n)) : 1;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: x[0] takes the newest sample on shift, with two
// combinational read ports for the mirrored taps x[k] and x[N-1-k].
module fir_delay_line #(
    parameter int N     = 16,
    parameter int W     = fir_pkg::DATA_W,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                shift_en_i,
    input  logic signed [W-1:0] din_i,
    input  logic [IDX_W-1:0]    rd_a_idx_i,
    input  logic [IDX_W-1:0]    rd_c_idx_i,
    output logic signed [W-1:0] rd_a_o,
    output logic signed [W-1:0] rd_c_o
);
    import fir_pkg::*;

    logic [N-1:0][W-1:0] x_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
        end else if (shift_en_i) begin
            x_q <= {x_q[N-2:0], din_i};
        end
    end

    always_comb begin
        rd_a_o = '0;
        rd_c_o = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_a_idx_i == IDX_W'(i)) rd_a_o = x_q[i];
            if (rd_c_idx_i == IDX_W'(i)) rd_c_o = x_q[i];
        end
    end

endmodule

// File: rtl/sym_fir_tap_seq.sv
// Tap-pair feeder for a symmetric FIR: per accepted sample, emits (x[k], x[N-1-k], h[k])
// for k = 0..pairs-1, one per cycle. Odd NUM_TAPS requires SYM_FIR_ODD_TAPS_EN.
module sym_fir_tap_seq #(
    parameter int NUM_TAPS = 16,
    parameter int DATA_W   = fir_pkg::DATA_W,
    parameter int COEF_W   = fir_pkg::COEF_W,
    parameter int ADDR_W   = fir_pkg::fir_addr_w(NUM_TAPS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic signed [DATA_W-1:0] s_data_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic                     coef_we_i,
    input  logic [ADDR_W-1:0]        coef_addr_i,
    input  logic signed [COEF_W-1:0] coef_data_i,
    output logic signed [DATA_W-1:0] a_o,
    output logic signed [DATA_W-1:0] c_o,
    output logic signed [COEF_W-1:0] b_o,
    output logic                     tap_valid_o,
    output logic                     first_o,
    output logic                     last_o
);
    import fir_pkg::*;

    localparam int NPAIR = fir_num_pairs(NUM_TAPS);
    localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    generate
        if (NUM_TAPS < 2) begin : g_chk_min
            $error("sym_fir_tap_seq: NUM_TAPS must be >= 2");
        end
`ifndef SYM_FIR_ODD_TAPS_EN
        if (NUM_TAPS % 2 != 0) begin : g_chk_even
            $error("sym_fir_tap_seq: odd NUM_TAPS needs SYM_FIR_ODD_TAPS_EN");
        end
`endif
        if (ADDR_W < KW) begin : g_chk_addr
            $error("sym_fir_tap_seq: ADDR_W too narrow for the coefficient bank");
        end
    endgenerate

    seq_state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          k_last;
    logic          shift_en;

    logic [NPAIR-1:0][COEF_W-1:0] h_q;
    logic signed [COEF_W-1:0]     h_k;
    logic signed [DATA_W-1:0]     x_a, x_c, c_sel;
    logic [IDX_W-1:0]             a_idx, c_idx;

    assign k_last = (k_q == KW'(NPAIR - 1));
    assign a_idx  = IDX_W'(k_q);
    assign c_idx  = IDX_W'(NUM_TAPS - 1) - IDX_W'(k_q);

    fir_delay_line #(
        .N     (NUM_TAPS),
        .W     (DATA_W),
        .IDX_W (IDX_W)
    ) u_line (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .shift_en_i (shift_en),
        .din_i      (s_data_i),
        .rd_a_idx_i (a_idx),
        .rd_c_idx_i (c_idx),
        .rd_a_o     (x_a),
        .rd_c_o     (x_c)
    );

    // Out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
        end else if (coef_we_i) begin
            for (int i = 0; i < NPAIR; i++) begin
                if (coef_addr_i == ADDR_W'(i)) h_q[i] <= coef_data_i;
            end
        end
    end

    always_comb begin
        h_k = '0;
        for (int i = 0; i < NPAIR; i++) begin
            if (k_q == KW'(i)) h_k = h_q[i];
        end
    end

`ifdef SYM_FIR_ODD_TAPS_EN
    localparam bit ODD = (NUM_TAPS % 2) == 1;
    // The centre tap of an odd filter pairs with nothing.
    assign c_sel = (ODD && k_last) ? '0 : x_c;
`else
    assign c_sel = x_c;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Ready opens on the last pair so the next sample starts with no bubble.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        s_ready_o = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    shift_en = 1'b1;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (k_last) begin
                    s_ready_o = 1'b1;
                    k_d       = '0;
                    if (s_valid_i) shift_en = 1'b1;
                    else           state_d  = IDLE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captures pre-shift line values, so a sample's last pair never sees its successor.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_o         <= '0;
            c_o         <= '0;
            b_o         <= '0;
            tap_valid_o <= 1'b0;
            first_o     <= 1'b0;
            last_o      <= 1'b0;
        end else if (state_q == RUN) begin
            a_o         <= x_a;
            c_o         <= c_sel;
            b_o         <= h_k;
            tap_valid_o <= 1'b1;
            first_o     <= (k_q == '0);
            last_o      <= k_last;
        end else begin
            a_o         <= '0;
            c_o         <= '0;
            b_o         <= '0;
            tap_valid_o <= 1'b0;
            first_o     <= 1'b0;
            last_o      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sym_fir_tap_seq.sv
// Bench for sym_fir_tap_seq: queue-based pair model on an N=4 instance, literal
// checks on N=4 and N=16 instances, plus N=5 when SYM_FIR_ODD_TAPS_EN is defined.
module tb_sym_fir_tap_seq;
    import fir_pkg::*;

    localparam int MN = 4;
    localparam int NP = MN / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // N=4 instance, address port widened so index 2 is representable
    logic       rst_n, s_valid, dm_rdy, coef_we, dm_tv, dm_first, dm_last;
    logic [1:0] coef_addr;
    sample_t    s_data, dm_a, dm_c;
    coef_t      coef_data, dm_b;

    sym_fir_tap_seq #(.NUM_TAPS(MN), .ADDR_W(2)) dm (
        .clk_i(clk), .rst_ni(rst_n), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(dm_rdy),
        .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
        .a_o(dm_a), .c_o(dm_c), .b_o(dm_b), .tap_valid_o(dm_tv), .first_o(dm_first), .last_o(dm_last)
    );

    // N=16 instance
    logic       r16_n, v16, rdy16, we16, tv16, first16, last16;
    logic [2:0] addr16;
    sample_t    d16, a16, c16;
    coef_t      h16, b16;

    sym_fir_tap_seq #(.NUM_TAPS(16)) d16u (
        .clk_i(clk), .rst_ni(r16_n), .s_data_i(d16), .s_valid_i(v16), .s_ready_o(rdy16),
        .coef_we_i(we16), .coef_addr_i(addr16), .coef_data_i(h16),
        .a_o(a16), .c_o(c16), .b_o(b16), .tap_valid_o(tv16), .first_o(first16), .last_o(last16)
    );

`ifdef SYM_FIR_ODD_TAPS_EN
    logic       v5, rdy5, we5, tv5, first5, last5;
    logic [1:0] addr5;
    sample_t    d5, a5, c5;
    coef_t      h5, b5;

    sym_fir_tap_seq #(.NUM_TAPS(5)) d5u (
        .clk_i(clk), .rst_ni(rst_n), .s_data_i(d5), .s_valid_i(v5), .s_ready_o(rdy5),
        .coef_we_i(we5), .coef_addr_i(addr5), .coef_data_i(h5),
        .a_o(a5), .c_o(c5), .b_o(b5), .tap_valid_o(tv5), .first_o(first5), .last_o(last5)
    );
`endif

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Model: a queue of pending pairs per accepted sample; coefficients resolved at emission.
    typedef struct { sample_t a; sample_t c; int k; } pair_t;
    sample_t mx [MN];
    coef_t   mh [NP];
    pair_t   pq [$];
    logic    e_v, e_first, e_last;
    sample_t e_a, e_c;
    coef_t   e_b;
    bit      acc;

    task automatic step();
        bit    m_rdy;
        pair_t p;
        @(negedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            foreach (mx[i]) mx[i] = '0;
            foreach (mh[i]) mh[i] = '0;
            pq.delete();
            {e_v, e_first, e_last} = 3'b000;
            e_a = '0; e_c = '0; e_b = '0;
            chk("reset a", dm_a, 0);
            chk("reset b", dm_b, 0);
            chk("reset c", dm_c, 0);
        end
        chk("tap_valid", dm_tv, e_v);
        chk("first", dm_first, e_first);
        chk("last", dm_last, e_last);
        if (e_v) begin
            chk("a", dm_a, e_a);
            chk("b", dm_b, e_b);
            chk("c", dm_c, e_c);
        end
        m_rdy = (pq.size() <= 1);
        chk("s_ready", dm_rdy, m_rdy);
        if (rst_n) begin
            if (pq.size() > 0) begin
                p = pq.pop_front();
                e_v = 1'b1; e_a = p.a; e_c = p.c; e_b = mh[p.k];
                e_first = (p.k == 0); e_last = (p.k == NP - 1);
            end else begin
                {e_v, e_first, e_last} = 3'b000;
            end
            if (s_valid && m_rdy) begin
                acc = 1'b1;
                for (int i = MN - 1; i > 0; i--) mx[i] = mx[i-1];
                mx[0] = s_data;
                for (int k = 0; k < NP; k++) pq.push_back('{a: mx[k], c: mx[MN-1-k], k: k});
            end
            if (coef_we && int'(coef_addr) < NP) mh[int'(coef_addr)] = coef_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    int gap;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        r16_n = 1'b0; v16 = 1'b0; d16 = '0; we16 = 1'b0; addr16 = '0; h16 = '0;
`ifdef SYM_FIR_ODD_TAPS_EN
        v5 = 1'b0; d5 = '0; we5 = 1'b0; addr5 = '0; h5 = '0;
`endif
        // reset then idle
        repeat (3) step();
        rst_n = 1'b1; r16_n = 1'b1;
        repeat (3) begin
            step();
            chk("idle tv", dm_tv, 0);
            chk("idle ready", dm_rdy, 1);
            chk("idle a", dm_a, 0);
            chk("idle first", dm_first, 0);
            chk("idle last", dm_last, 0);
        end

        // single sample x=7 with h={3,-5}
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = coef_t'(3); step();
        coef_addr = 2'd1; coef_data = coef_t'(-5); step();
        coef_we = 1'b0;
        s_valid = 1'b1; s_data = sample_t'(7); step();
        s_valid = 1'b0;
        step();
        chk("single p0 a", dm_a, 7); chk("single p0 c", dm_c, 0); chk("single p0 b", dm_b, 3);
        chk("single p0 first", dm_first, 1); chk("single p0 tv", dm_tv, 1);
        step();
        chk("single p1 a", dm_a, 0); chk("single p1 c", dm_c, 0); chk("single p1 b", dm_b, -5);
        chk("single p1 last", dm_last, 1);
        step();
        chk("single after tv", dm_tv, 0);

        // back-to-back stream 1..4
        s_valid = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            s_data = sample_t'(v);
            gap = 0;
            do begin step(); gap++; end while (!acc && gap < 8);
            if (!acc) chk("stream accept timeout", 0, 1);
            if (v > 1) chk("stream ready spacing", gap, 2);
        end
        s_valid = 1'b0;
        step();
        chk("stream s4 p0 a", dm_a, 4); chk("stream s4 p0 c", dm_c, 1); chk("stream s4 p0 b", dm_b, 3);
        step();
        chk("stream s4 p1 a", dm_a, 3); chk("stream s4 p1 c", dm_c, 2); chk("stream s4 p1 b", dm_b, -5);
        step();

        // coefficient write during the read of h[1], then an out-of-range write
        s_valid = 1'b1; s_data = sample_t'(10); step();
        s_valid = 1'b0; step();
        coef_we = 1'b1; coef_addr = 2'd1; coef_data = coef_t'(9); step();
        chk("wr same-cycle old b", dm_b, -5); chk("wr same-cycle a", dm_a, 4); chk("wr same-cycle c", dm_c, 3);
        coef_addr = 2'd2; coef_data = coef_t'(77); step();
        coef_we = 1'b0;
        s_valid = 1'b1; s_data = sample_t'(11); step();
        s_valid = 1'b0; step();
        chk("wr next p0 a", dm_a, 11); chk("wr next p0 c", dm_c, 3); chk("wr next p0 b", dm_b, 3);
        step();
        chk("wr next p1 a", dm_a, 10); chk("wr next p1 c", dm_c, 4); chk("wr next p1 b", dm_b, 9);
        step();

        // N=16: stream 1..5, reset at k=5
        we16 = 1'b1; addr16 = 3'd4; h16 = coef_t'(-2); step();
        we16 = 1'b0;
        v16 = 1'b1; d16 = sample_t'(1); step();
        for (int v = 2; v <= 5; v++) begin
            d16 = sample_t'(v);
            repeat (8) step();
        end
        v16 = 1'b0;
        step();
        chk("n16 p0 a", a16, 5); chk("n16 p0 first", first16, 1);
        repeat (4) step();
        chk("n16 p4 a", a16, 1); chk("n16 p4 b", b16, -2); chk("n16 p4 c", c16, 0); chk("n16 p4 tv", tv16, 1);
        r16_n = 1'b0;
        #1;
        chk("n16 rst a", a16, 0); chk("n16 rst b", b16, 0); chk("n16 rst tv", tv16, 0);
        chk("n16 rst first", first16, 0); chk("n16 rst last", last16, 0);
        step();
        r16_n = 1'b1;
        v16 = 1'b1; d16 = sample_t'(9); step();
        v16 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("n16 post a", a16, (k == 0) ? 9 : 0);
            chk("n16 post c", c16, 0);
            chk("n16 post b", b16, 0);
            chk("n16 post last", last16, (k == 7) ? 1 : 0);
        end
        step();

`ifdef SYM_FIR_ODD_TAPS_EN
        // N=5: line {5,4,3,2,1} with h={1,2,3}
        we5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr5 = 2'(i); h5 = coef_t'(i + 1); step();
        end
        we5 = 1'b0;
        v5 = 1'b1; d5 = sample_t'(1); step();
        for (int v = 2; v <= 5; v++) begin
            d5 = sample_t'(v);
            repeat (3) step();
        end
        v5 = 1'b0;
        step();
        chk("odd p0 a", a5, 5); chk("odd p0 c", c5, 1); chk("odd p0 b", b5, 1); chk("odd p0 first", first5, 1);
        step();
        chk("odd p1 a", a5, 4); chk("odd p1 c", c5, 2); chk("odd p1 b", b5, 2);
        step();
        chk("odd p2 a", a5, 3); chk("odd p2 c", c5, 0); chk("odd p2 b", b5, 3); chk("odd p2 last", last5, 1);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sym_fir_tap_seq.md
Name: sym_fir_tap_seq

Overview:
- Upstream feeder for the symmetric-FIR pre-adder/multiplier stage.
- Holds the sample delay line and the half-length coefficient bank.
- For each accepted input sample, it emits one tap pair per cycle: a = x[k], c = x[N-1-k], b = h[k].
- The downstream stage computes (a+c)*b. A later accumulator sums the products between first and last markers.

Parameters:
- NUM_TAPS, 16, total FIR length N; must be even (see Optional Feature); must be >= 2.
- DATA_W, 24, signed sample width; drives a_o/c_o.
- COEF_W, 18, signed coefficient width; drives b_o.
- ADDR_W, $clog2(NUM_TAPS/2) with minimum 1, coefficient address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- s_data_i  in  DATA_W  signed input sample.
- s_valid_i  in  1  sample valid.
- s_ready_o  out  1  sample accepted when s_valid_i && s_ready_o.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  ADDR_W  coefficient index k.
- coef_data_i  in  COEF_W  signed coefficient h[k].
- a_o  out  DATA_W  registered x[k].
- c_o  out  DATA_W  registered x[N-1-k].
- b_o  out  COEF_W  registered h[k].
- tap_valid_o  out  1  a_o/b_o/c_o hold a valid pair.
- first_o  out  1  pair k=0 of the current sample.
- last_o  out  1  pair k=N/2-1 of the current sample.

Behaviour:
- Reset (rst_ni low, async):
  - Delay line x[0..N-1] = 0 and coefficient bank = 0.
  - a_o, b_o, c_o, tap_valid_o, first_o, last_o = 0.
  - State = IDLE, k = 0.
- States:
  - IDLE: s_ready_o = 1, tap_valid_o = 0 next cycle. On accept: shift the delay line (x[i] <= x[i-1], x[0] <= s_data_i), k <= 0, go to RUN.
  - RUN: each cycle register a_o = x[k], c_o = x[N-1-k], b_o = h[k], tap_valid_o = 1, first_o = (k==0), last_o = (k==N/2-1), then k++.
    - When k == N/2-1: s_ready_o = 1 (combinational).
      - Accept in that cycle: shift and restart at k=0, staying in RUN. This sustains one sample per N/2 cycles with no bubble.
      - No accept: go to IDLE.
    - When k != N/2-1: s_ready_o = 0.
- Same-edge rule: output registers capture the pre-shift delay-line values, so the last pair of sample n never sees sample n+1.
- Latency: sample accepted at edge t.
  - First pair is visible after edge t+1; last pair after edge t+N/2.
  - Downstream product follows 2 cycles later.
- Coefficients:
  - Writes are accepted in any state and are visible to reads from the next cycle.
  - A write to the index read in the same cycle returns the old value.
  - coef_addr_i >= N/2 is ignored.
- Arithmetic: none in this block; values pass through bit-exact and signed.
- No backpressure from downstream: the pre-adder always accepts.
- Reset asserted mid-RUN: all outputs clear immediately, and the partial sample sequence is discarded.

Optional Feature:
- Macro SYM_FIR_ODD_TAPS_EN.
- Defined:
  - NUM_TAPS may be odd; the pair count becomes (N+1)/2.
  - The final pair k=(N-1)/2 drives a_o = x[k], c_o = 0, b_o = h[k], last_o = 1.
  - The coefficient bank has (N+1)/2 entries.
- Not defined: odd NUM_TAPS is an elaboration error ($error), and behaviour is as above.

Decomposition:
- Package fir_pkg:
  - DATA_W, COEF_W and the product-width constant (DATA_W+1+COEF_W, which is 43 at defaults).
  - typedef enum logic {IDLE, RUN} seq_state_e.
  - Signed typedefs sample_t and coef_t.
- Sub-module fir_delay_line:
  - Parameterised shift register with a shift enable.
  - Two combinational read ports, indexed by k and N-1-k.
  - Async active-low reset to zero.

Test Plan:
- Reset then idle: hold rst_ni=0 for 3 cycles, release, no s_valid_i -> all outputs 0, s_ready_o=1, tap_valid_o stays 0.
- Single sample, N=4, h={3,-5}, empty line, send x=7:
  - Cycle 1: a=7, c=0, b=3, first=1.
  - Cycle 2: a=0, c=0, b=-5, last=1.
  - Then tap_valid_o=0.
- Back-to-back stream, N=4, s_valid_i held high with 1, 2, 3, 4 -> s_ready_o pulses every 2nd cycle, and tap_valid_o stays high continuously. For sample 4: pairs (a=4, c=1, b=h0) and (a=3, c=2, b=h1).
- Coefficient write during RUN: write h[1]=9 in the same cycle k=1 is read -> that pair still shows the old h[1]; the next sample shows 9. A write to address 2 (N=4) is ignored.
- Reset mid-RUN, N=16: assert rst_ni at k=5 -> outputs are 0 in the same cycle, and after release the delay line reads all zeros.
- Odd taps (SYM_FIR_ODD_TAPS_EN, N=5), line {5,4,3,2,1} (x[0]=5) -> pairs (5,1), (4,2), (3,0), with last_o on the third pair.
